// File: rtl/cache_refill_ctrl_pkg.sv
// Shared cache refill definitions: FSM state encoding, line geometry and fixed AXI attributes.
package cache_refill_ctrl_pkg;
  localparam int         CL_LINE_WORDS  = 16;
  localparam int         CL_ADDR_WD     = 32;
  localparam logic [3:0] AXI_ID         = 4'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFILL, DONE
  } state_e;
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// AXI read/write channel bundle between the refill controller (master) and memory (slave).
interface cache_refill_ctrl_if #(parameter int ADDR_WD = 32);
  logic               arvalid, arready;
  logic [ADDR_WD-1:0] araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [3:0]         arid;
  logic               rvalid, rready, rlast;
  logic [ADDR_WD-1:0] rdata;
  logic               awvalid, awready;
  logic [ADDR_WD-1:0] awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic [3:0]         awid;
  logic               wvalid, wready, wlast;
  logic [ADDR_WD-1:0] wdata;
  logic               bvalid, bready;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
           awvalid, awaddr, awlen, awsize, awburst, awid,
           wvalid, wdata, wlast, bready,
    input  arready, rvalid, rdata, rlast, awready, wready, bvalid
  );
  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
           awvalid, awaddr, awlen, awsize, awburst, awid,
           wvalid, wdata, wlast, bready,
    output arready, rvalid, rdata, rlast, awready, wready, bvalid
  );
endinterface

// File: rtl/cache_line_buf.sv
// Refill line assembly buffer: one word written per accepted read beat, whole line visible.
module cache_line_buf #(
  parameter int LINE_WORDS = 16,
  parameter int WORD_W     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0]  wr_idx,
  input  logic [WORD_W-1:0]              wr_data,
  output logic [LINE_WORDS*WORD_W-1:0]   line
);
  logic [LINE_WORDS-1:0][WORD_W-1:0] mem;

  // Words not rewritten by a short burst keep their previous contents.
  always_ff @(posedge clk) begin
    if (reset)      mem <= '0;
    else if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign line = mem;
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: optional dirty-victim writeback, then AXI read into the line buffer.
// Define CACHE_WB_BUFFER_EN to overlap the writeback data/response with the refill read.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = CL_LINE_WORDS,
  parameter int ADDR_WD    = CL_ADDR_WD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss,
  input  logic                          cached,
  input  logic                          write_back,
  input  logic [ADDR_WD-1:0]            axi_raddr,
  input  logic [ADDR_WD-1:0]            axi_waddr,
  input  logic [LINE_WORDS*ADDR_WD-1:0] victim_line,
  cache_refill_ctrl_if.master           axi,
  output logic                          refresh,
  output logic [LINE_WORDS*ADDR_WD-1:0] refill_line,
  output logic [ADDR_WD-1:0]            uncached_rdata,
  output logic                          uncached_valid,
  output logic                          busy
);
  localparam int              BW        = $clog2(LINE_WORDS);
  localparam logic [7:0]      BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_WORDS - 1);

  state_e                             state, state_nxt;
  logic                               cached_q;
  logic [ADDR_WD-1:0]                 raddr_q, waddr_q;
  logic [LINE_WORDS-1:0][ADDR_WD-1:0] victim_q;
  logic [BW-1:0]                      wbeat, rbeat;
  logic                               w_fire, r_fire, wb_wait, rd_hold;

  assign w_fire = axi.wvalid & axi.wready;
  assign r_fire = axi.rvalid & axi.rready;

`ifdef CACHE_WB_BUFFER_EN
  // W/B channels run from the victim copy while the main FSM does the read; WB_B is the join point.
  localparam state_e AW_NEXT = RD_AR;
  localparam state_e B_NEXT  = REFILL;
  logic wr_w, wr_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_w <= 1'b0;
      wr_b <= 1'b0;
    end else begin
      if (state == WB_AW && axi.awready) wr_w <= 1'b1;
      if (w_fire && axi.wlast) begin
        wr_w <= 1'b0;
        wr_b <= 1'b1;
      end
      if (wr_b && axi.bvalid) wr_b <= 1'b0;
    end
  end
  assign axi.wvalid = wr_w;
  assign axi.bready = wr_b;
  assign wb_wait    = wr_w | (wr_b & ~axi.bvalid);
  assign rd_hold    = wb_wait;
`else
  localparam state_e AW_NEXT = WB_W;
  localparam state_e B_NEXT  = RD_AR;
  assign axi.wvalid = (state == WB_W);
  assign axi.bready = (state == WB_B);
  assign wb_wait    = ~axi.bvalid;
  assign rd_hold    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (miss) state_nxt = (cached && write_back) ? WB_AW : RD_AR;
      WB_AW:   if (axi.awready) state_nxt = AW_NEXT;
      WB_W:    if (w_fire && axi.wlast) state_nxt = WB_B;
      WB_B:    if (!wb_wait) state_nxt = B_NEXT;
      RD_AR:   if (axi.arready) state_nxt = RD_R;
      // rlast ends the burst even if it arrives early
      RD_R:    if (r_fire && axi.rlast)
                 state_nxt = !cached_q ? DONE : (rd_hold ? WB_B : REFILL);
      REFILL:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cached_q       <= 1'b0;
      raddr_q        <= '0;
      waddr_q        <= '0;
      victim_q       <= '0;
      wbeat          <= '0;
      rbeat          <= '0;
      uncached_rdata <= '0;
    end else begin
      if (state == IDLE && miss) begin
        cached_q <= cached;
        raddr_q  <= axi_raddr;
        waddr_q  <= axi_waddr;
        victim_q <= victim_line;
        wbeat    <= '0;
        rbeat    <= '0;
      end
      if (w_fire) wbeat <= wbeat + BW'(1);
      if (r_fire) begin
        rbeat <= rbeat + BW'(1);
        if (axi.rlast && !cached_q) uncached_rdata <= axi.rdata;
      end
    end
  end

  cache_line_buf #(.LINE_WORDS(LINE_WORDS), .WORD_W(ADDR_WD)) u_line_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (r_fire),
    .wr_idx  (rbeat),
    .wr_data (axi.rdata),
    .line    (refill_line)
  );

  assign axi.awvalid  = (state == WB_AW);
  assign axi.awaddr   = waddr_q;
  assign axi.awlen    = BURST_LEN;
  assign axi.awsize   = AXI_SIZE_WORD;
  assign axi.awburst  = AXI_BURST_INCR;
  assign axi.awid     = AXI_ID;
  assign axi.wdata    = victim_q[wbeat];
  assign axi.wlast    = axi.wvalid && (wbeat == LAST_BEAT);
  assign axi.arvalid  = (state == RD_AR);
  assign axi.araddr   = raddr_q;
  assign axi.arlen    = cached_q ? BURST_LEN : 8'd0;
  assign axi.arsize   = AXI_SIZE_WORD;
  assign axi.arburst  = AXI_BURST_INCR;
  assign axi.arid     = AXI_ID;
  assign axi.rready   = (state == RD_R);
  assign refresh        = (state == REFILL);
  assign uncached_valid = (state == DONE) && !cached_q;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboarded bench for cache_refill_ctrl: memory slave model on the falling edge, scenario tasks in sequence.
module tb_cache_refill_ctrl;
  localparam int LW = 16;

  logic           clk = 1'b0;
  logic           reset, miss, cached, write_back;
  logic [31:0]    axi_raddr, axi_waddr, uncached_rdata;
  logic [LW*32-1:0] victim_line, refill_line;
  logic           refresh, uncached_valid, busy;

  cache_refill_ctrl_if #(.ADDR_WD(32)) axi ();

  cache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_WD(32)) dut (
    .clk(clk), .reset(reset), .miss(miss), .cached(cached), .write_back(write_back),
    .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .victim_line(victim_line), .axi(axi),
    .refresh(refresh), .refill_line(refill_line), .uncached_rdata(uncached_rdata),
    .uncached_valid(uncached_valid), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef CACHE_WB_BUFFER_EN
  localparam int DIRTY_LAT = 20;
`else
  localparam int DIRTY_LAT = 37;
`endif

  int checks = 0, errors = 0;
  bit stall = 0;
  int early_last = -1;
  logic [31:0] r_base = '0;
  int r_left = 0, r_idx = 0, w_idx = 0;
  bit b_pend = 0, wb_open = 0;

  logic [31:0]      q_ar_addr[$], q_aw_addr[$], q_w[$], q_unc[$];
  logic [7:0]       q_ar_len[$], q_aw_len[$];
  logic [LW*32-1:0] q_line[$];
  logic [LW-1:0][31:0] mdl = '0;   // expected refill buffer contents

  logic [31:0]      m_a;
  logic [7:0]       m_l;
  logic [LW*32-1:0] m_line;

  // Slave + scoreboard: pick this cycle's inputs, then account for handshakes at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
      r_left = 0; r_idx = 0; w_idx = 0; b_pend = 0; wb_open = 0;
    end else begin
      axi.arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.rvalid  = (r_left > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      axi.rdata   = r_base + 32'(r_idx);
      axi.rlast   = (r_left == 1) || (r_idx == early_last);
      axi.bvalid  = b_pend;

      if (axi.awvalid && axi.awready) begin
        checks++;
        if (q_aw_addr.size() == 0) begin
          errors++; $display("FAIL aw_unexpected got addr=%h", axi.awaddr);
        end else begin
          m_a = q_aw_addr.pop_front(); m_l = q_aw_len.pop_front();
          if (axi.awaddr !== m_a || axi.awlen !== m_l || axi.awsize !== 3'd2 || axi.awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=2 burst=1",
                     axi.awaddr, axi.awlen, axi.awsize, axi.awburst, m_a, m_l);
          end
        end
        wb_open = 1;
      end
      if (axi.wvalid && axi.wready) begin
        checks++;
        if (q_w.size() == 0) begin
          errors++; $display("FAIL w_unexpected got data=%h", axi.wdata);
        end else begin
          m_a = q_w.pop_front();
          if (axi.wdata !== m_a || axi.wlast !== (w_idx == LW - 1)) begin
            errors++;
            $display("FAIL w_beat%0d got data=%h last=%b want data=%h last=%b",
                     w_idx, axi.wdata, axi.wlast, m_a, (w_idx == LW - 1));
          end
        end
        w_idx++;
        if (axi.wlast) begin b_pend = 1; w_idx = 0; end
      end
      if (axi.bvalid && axi.bready) begin b_pend = 0; wb_open = 0; end
      if (axi.arvalid && axi.arready) begin
`ifndef CACHE_WB_BUFFER_EN
        checks++;
        if (wb_open) begin errors++; $display("FAIL ar_before_b got wb_open=1 want 0"); end
`endif
        checks++;
        if (q_ar_addr.size() == 0) begin
          errors++; $display("FAIL ar_unexpected got addr=%h", axi.araddr);
        end else begin
          m_a = q_ar_addr.pop_front(); m_l = q_ar_len.pop_front();
          if (axi.araddr !== m_a || axi.arlen !== m_l || axi.arsize !== 3'd2 || axi.arburst !== 2'b01 || axi.arid !== 4'd0) begin
            errors++;
            $display("FAIL ar got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=2 burst=1",
                     axi.araddr, axi.arlen, axi.arsize, axi.arburst, m_a, m_l);
          end
        end
        r_left = int'(axi.arlen) + 1; r_idx = 0;
      end
      if (axi.rvalid && axi.rready) begin
        r_idx++;
        r_left = axi.rlast ? 0 : r_left - 1;
      end
      if (refresh) begin
        checks++;
        if (q_line.size() == 0) begin
          errors++; $display("FAIL refresh_unexpected got refresh=1 want 0");
        end else begin
          m_line = q_line.pop_front();
          if (refill_line !== m_line) begin
            errors++; $display("FAIL refill_line got %h want %h", refill_line, m_line);
          end
        end
      end
      if (uncached_valid) begin
        checks++;
        if (q_unc.size() == 0) begin
          errors++; $display("FAIL uncached_unexpected got %h", uncached_rdata);
        end else begin
          m_a = q_unc.pop_front();
          if (uncached_rdata !== m_a) begin
            errors++; $display("FAIL uncached_rdata got %h want %h", uncached_rdata, m_a);
          end
        end
      end
    end
  end

  function automatic int pending();
    return q_line.size() + q_unc.size() + q_w.size() + q_ar_addr.size() + q_aw_addr.size();
  endfunction

  task automatic push_read(input logic [31:0] ra, input logic c, input logic [31:0] base, input int nb);
    q_ar_addr.push_back(ra);
    q_ar_len.push_back(c ? 8'd15 : 8'd0);
    for (int i = 0; i < nb; i++) mdl[i] = base + 32'(i);
    if (c) q_line.push_back(mdl);
    else   q_unc.push_back(base + 32'(nb - 1));
  endtask

  task automatic push_wb(input logic [31:0] wa, input logic [LW*32-1:0] vl);
    q_aw_addr.push_back(wa);
    q_aw_len.push_back(8'd15);
    for (int i = 0; i < LW; i++) q_w.push_back(vl[i*32 +: 32]);
  endtask

  // One-cycle miss pulse; inputs are scrambled afterwards since the DUT must hold its own copies.
  task automatic start_miss(input logic c, input logic wb, input logic [31:0] ra,
                            input logic [31:0] wa, input logic [LW*32-1:0] vl);
    miss = 1'b1; cached = c; write_back = wb; axi_raddr = ra; axi_waddr = wa; victim_line = vl;
    @(posedge clk); #1;
    miss = 1'b0; cached = ~c; axi_raddr = ~ra; axi_waddr = ~wa; victim_line = ~vl;
  endtask

  task automatic run_to_refresh(output int lat);
    lat = 2;
    while (refresh !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin ok = 1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; miss = 1'b0; cached = 1'b0; write_back = 1'b0;
    axi_raddr = '0; axi_waddr = '0; victim_line = '0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, refresh, uncached_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_status got busy/refresh/uv=%b want 000", {busy, refresh, uncached_valid});
    end
    checks++;
    if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b want 00000",
                         {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
    end
    checks++;
    if (refill_line !== '0 || uncached_rdata !== '0) begin
      errors++; $display("FAIL reset_data got uncached_rdata=%h want 0 (line nonzero=%b)", uncached_rdata, refill_line != '0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_miss got busy=%b want 0", busy); end
  endtask

  task automatic test_clean_miss();
    int lat; bit ok;
    r_base = 32'h0;
    push_read(32'h1C00_0040, 1'b1, r_base, LW);
    start_miss(1'b1, 1'b0, 32'h1C00_0040, 32'h0, '0);
    run_to_refresh(lat);
    checks++;
    if (lat != 19) begin errors++; $display("FAIL clean_latency got %0d want 19", lat); end
    checks++;
    if (refill_line[31:0] !== 32'h0 || refill_line[511:480] !== 32'hF) begin
      errors++; $display("FAIL clean_words got w0=%h w15=%h want 0 / f", refill_line[31:0], refill_line[511:480]);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || pending() != 0) begin errors++; $display("FAIL clean_done got idle=%b pending=%0d want 1/0", ok, pending()); end
  endtask

  task automatic test_dirty_miss();
    int lat; bit ok;
    logic [LW*32-1:0] vl;
    for (int i = 0; i < LW; i++) vl[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    r_base = 32'h100;
    push_wb(32'h0000_1FC0, vl);
    push_read(32'h0000_2000, 1'b1, r_base, LW);
    start_miss(1'b1, 1'b1, 32'h0000_2000, 32'h0000_1FC0, vl);
    run_to_refresh(lat);
    checks++;
    if (lat != DIRTY_LAT) begin errors++; $display("FAIL dirty_latency got %0d want %0d", lat, DIRTY_LAT); end
    wait_idle(50, ok);
    checks++;
    if (!ok || pending() != 0) begin errors++; $display("FAIL dirty_done got idle=%b pending=%0d want 1/0", ok, pending()); end
  endtask

  task automatic test_uncached();
    int n_unc = 0, n_ref = 0; bit ok;
    logic [31:0] got = '0;
    r_base = 32'hCAFE_0000;
    push_read(32'hBFAF_8000, 1'b0, r_base, 1);
    start_miss(1'b0, 1'b1, 32'hBFAF_8000, 32'h1234_5678, '1);
    for (int i = 0; i < 100 && busy === 1'b1; i++) begin
      if (uncached_valid === 1'b1) begin n_unc++; got = uncached_rdata; end
      if (refresh === 1'b1) n_ref++;
      @(posedge clk); #1;
    end
    wait_idle(1, ok);
    checks++;
    if (!ok || n_unc != 1 || n_ref != 0) begin
      errors++; $display("FAIL uncached_pulses got idle=%b uv=%0d refresh=%0d want 1/1/0", ok, n_unc, n_ref);
    end
    checks++;
    if (got !== 32'hCAFE_0000) begin errors++; $display("FAIL uncached_data got %h want cafe0000", got); end
    checks++;
    if (pending() != 0) begin errors++; $display("FAIL uncached_drain got pending=%0d want 0", pending()); end
  endtask

  task automatic test_early_rlast();
    bit ok;
    early_last = 5;
    r_base = 32'h5500;
    push_read(32'h0000_4000, 1'b1, r_base, 6);
    start_miss(1'b1, 1'b0, 32'h0000_4000, 32'h0, '0);
    wait_idle(60, ok);
    early_last = -1;
    checks++;
    if (!ok || pending() != 0) begin errors++; $display("FAIL early_rlast got idle=%b pending=%0d want 1/0", ok, pending()); end
  endtask

  task automatic test_stalls();
    bit ok;
    logic [LW*32-1:0] vl;
    logic [31:0] ra, wa;
    stall = 1;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < LW; i++) vl[i*32 +: 32] = $urandom;
      ra = $urandom & 32'hFFFF_FFC0; wa = $urandom & 32'hFFFF_FFC0;
      r_base = $urandom;
      if (n[0] == 1'b0) push_wb(wa, vl);
      push_read(ra, 1'b1, r_base, LW);
      start_miss(1'b1, (n[0] == 1'b0), ra, wa, vl);
      wait_idle(600, ok);
      checks++;
      if (!ok || pending() != 0) begin errors++; $display("FAIL stall_iter%0d got idle=%b pending=%0d want 1/0", n, ok, pending()); end
    end
    stall = 0;
  endtask

  task automatic test_reset_mid();
    int lat; bit ok;
    r_base = 32'h7000;
    q_ar_addr.push_back(32'h0000_8000); q_ar_len.push_back(8'd15);
    start_miss(1'b1, 1'b0, 32'h0000_8000, 32'h0, '0);
    for (int i = 0; i < 60 && r_idx != 7; i++) begin @(posedge clk); #1; end
    checks++;
    if (r_idx != 7) begin errors++; $display("FAIL reset_mid_reach got beat=%0d want 7", r_idx); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, refresh, uncached_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 8'b0) begin
      errors++; $display("FAIL reset_mid_outputs got %b want 00000000",
        {busy, refresh, uncached_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
    end
    reset = 1'b0;
    mdl = '0;
    @(posedge clk); #1;
    r_base = 32'h7100;
    push_read(32'h0000_8040, 1'b1, r_base, LW);
    start_miss(1'b1, 1'b0, 32'h0000_8040, 32'h0, '0);
    run_to_refresh(lat);
    checks++;
    if (lat != 19) begin errors++; $display("FAIL post_reset_latency got %0d want 19", lat); end
    wait_idle(50, ok);
    checks++;
    if (!ok || pending() != 0) begin errors++; $display("FAIL post_reset_done got idle=%b pending=%0d want 1/0", ok, pending()); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_uncached();
    test_early_rlast();
    test_stalls();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, meaning words per cache line (64 B line, 6-bit offset).
REQ-002 SHALL have parameter ADDR_WD, default 32, meaning address and data width.
REQ-003 SHALL have ports: clk input 1, the single clock; reset input 1, synchronous active-high.
REQ-004 SHALL have inputs: miss 1 (tag miss); cached 1; write_back 1 (dirty victim); axi_raddr 32 (line-aligned if cached); axi_waddr 32 (victim line address); victim_line 512 (victim data from the data array).
REQ-005 SHALL have AXI read outputs arvalid 1, araddr 32, arlen 8, with inputs arready 1, rvalid 1, rdata 32, rlast 1; rready 1 is an output.
REQ-006 SHALL have AXI write outputs awvalid 1, awaddr 32, awlen 8, wvalid 1, wdata 32, wlast 1, bready 1, with inputs awready 1, wready 1, bvalid 1.
REQ-007 SHALL have outputs: refresh 1 (tag/LRU update pulse); refill_line 512; uncached_rdata 32; uncached_valid 1; busy 1.

Function
REQ-008 SHALL implement FSM states IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFILL, DONE.
REQ-009 SHALL sample miss only in IDLE; on miss&cached&write_back go WB_AW; on miss otherwise go RD_AR; busy=1 in every state except IDLE.
REQ-010 SHALL latch axi_raddr, axi_waddr, cached and victim_line on the IDLE exit edge; later input changes are ignored until IDLE.
REQ-011 WB_AW: awvalid=1, awaddr=latched waddr, awlen=LINE_WORDS-1; on awready go WB_W.
REQ-012 WB_W: wvalid=1, wdata=victim word[beat], 4-bit beat counter from 0, increment on wready; wlast=1 at beat LINE_WORDS-1; on wready&wlast go WB_B.
REQ-013 WB_B: bready=1; on bvalid go RD_AR.
REQ-014 RD_AR: arvalid=1, araddr=latched raddr, arlen=LINE_WORDS-1 if cached else 0; on arready go RD_R.
REQ-015 RD_R: rready=1; each rvalid writes rdata into refill buffer word[beat], counter increments; on rvalid&rlast go REFILL if cached, else DONE with uncached_rdata=rdata and uncached_valid=1 for exactly that one DONE cycle.
REQ-016 REFILL: refresh=1 for exactly one cycle, refill_line=assembled buffer (word 0 at bits 31:0); go DONE.
REQ-017 DONE: one cycle ignoring miss (tag update settles); go IDLE.
REQ-018 Miss-to-refresh latency with zero-wait slave: clean line 1+1+16+1 = 19 cycles; dirty adds 1+16+1 = 18.
REQ-019 An early rlast (before counter reaches LINE_WORDS-1) SHALL still end RD_R; unfilled words hold stale data (slave protocol error, not corrected).
REQ-020 Valid signals SHALL stay asserted until handshake; AXI id=0, size=2, burst=INCR are fixed constants.

Reset
REQ-021 On reset (including mid-burst) SHALL go IDLE, clear beat counter, and drive all valid/ready outputs, refresh, uncached_valid and busy to 0; refill_line and uncached_rdata reset to 0.

Configuration
REQ-022 Macro CACHE_WB_BUFFER_EN defined: RD_AR/RD_R run concurrently with WB_W/WB_B from victim buffer; REFILL only after both bvalid and rlast seen; clean-miss latency unchanged.
REQ-023 Macro CACHE_WB_BUFFER_EN undefined: writeback fully completes (bvalid) before arvalid asserts, as REQ-011..015.

Structure
REQ-024 State encoding, LINE_WORDS, AXI size/burst constants SHALL live in the shared cache package.
REQ-025 The 16x32 refill buffer with word-indexed write SHALL be sub-module cache_line_buf.

Verification
REQ-026 Clean cached miss, raddr 0x1C000040, zero-wait slave -> arlen=15, 16 beats 0x0..0xF, refresh at cycle 19, refill_line[31:0]=0x0.
REQ-027 Dirty miss, waddr 0x00001FC0 -> AW awlen=15, 16 W beats with wlast on beat 15, AR issued only after bvalid (macro off).
REQ-028 Uncached miss, raddr 0xBFAF8000 -> arlen=0, uncached_valid=1 one cycle with rdata; refresh stays 0.
REQ-029 Random wready/rvalid stalls (50%) -> beat order preserved, no duplicated or dropped words.
REQ-030 Reset asserted during RD_R beat 7 -> next cycle IDLE, all valids 0; following miss completes normally.
